// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB hue-wheel LED controller.
// Segment encoding and duty register width derivation.
package rgb_pkg;

  typedef enum logic [2:0] {
    SEG_R_G_UP = 3'd0,
    SEG_G_R_DN = 3'd1,
    SEG_G_B_UP = 3'd2,
    SEG_B_G_DN = 3'd3,
    SEG_B_R_UP = 3'd4,
    SEG_B_R_DN = 3'd5
  } hue_seg_t;

  function automatic int duty_w(input int interval);
    return $clog2(interval + 1);
  endfunction

  // Wheel wraps from the last segment back to red.
  function automatic hue_seg_t next_seg(input hue_seg_t s);
    if (s == SEG_B_R_DN) return SEG_R_G_UP;
    return hue_seg_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/pwm_compare.sv
// Registered PWM comparator for one LED colour.
// Drives an active-low pin: low while cnt is below duty.
module pwm_compare
  import rgb_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  output logic         pin
);

  logic pin_d;
  logic pin_q;

  always_comb begin
    pin_d = ~(cnt < duty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_q <= 1'b1;
    end else begin
      pin_q <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule

// File: rtl/hue_sequencer.sv
// Colour-wheel controller: PWM period counter, hue sequencer
// and per-colour duty registers latched at the period boundary.
module hue_sequencer
  import rgb_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int DUTY_STEP    = 10,
  parameter int HOLD_PERIODS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] segment,
  output logic       period_start
);

  localparam int W = duty_w(PWM_INTERVAL);
  localparam logic [W-1:0] MAX       = W'(PWM_INTERVAL);
  localparam logic [W-1:0] LAST      = W'(PWM_INTERVAL - 1);
  localparam logic [W-1:0] STEP      = W'(DUTY_STEP);
  localparam logic [W-1:0] HOLD_LAST = W'(HOLD_PERIODS - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ps_q, ps_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] hold_q, hold_d;
  hue_seg_t     seg_q, seg_d;
  logic [W-1:0] duty_r_q, duty_r_d;
  logic [W-1:0] duty_g_q, duty_g_d;
  logic [W-1:0] duty_b_q, duty_b_d;

  logic         boundary;
  logic [W:0]   sum;
  logic [W-1:0] inv;
  logic [W-1:0] map_r, map_g, map_b;

  assign boundary = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ps_q     <= 1'b0;
      r_q      <= '0;
      hold_q   <= '0;
      seg_q    <= SEG_R_G_UP;
      duty_r_q <= MAX;
      duty_g_q <= '0;
      duty_b_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      r_q      <= r_d;
      hold_q   <= hold_d;
      seg_q    <= seg_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
    end
  end

  always_comb begin
    cnt_d  = boundary ? '0 : cnt_q + W'(1);
    ps_d   = boundary;
    seg_d  = seg_q;
    r_d    = r_q;
    hold_d = hold_q;
    sum    = {1'b0, r_q} + {1'b0, STEP};
    if (boundary && en) begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + W'(1);
      end else begin
        hold_d = '0;
        if (sum >= {1'b0, MAX}) begin
          r_d   = '0;
          seg_d = next_seg(seg_q);
        end else begin
          r_d = sum[W-1:0];
        end
      end
    end
  end

  // Map the upcoming (segment, ramp) to duties; only loaded at the boundary.
  always_comb begin
    map_r = '0;
    map_g = '0;
    map_b = '0;
    inv   = MAX - r_d;
    case (seg_d)
      SEG_R_G_UP: begin map_r = MAX; map_g = r_d; end
      SEG_G_R_DN: begin map_r = inv; map_g = MAX; end
      SEG_G_B_UP: begin map_g = MAX; map_b = r_d; end
      SEG_B_G_DN: begin map_g = inv; map_b = MAX; end
      SEG_B_R_UP: begin map_r = r_d; map_b = MAX; end
      SEG_B_R_DN: begin map_r = MAX; map_b = inv; end
      default:    begin map_r = MAX; end
    endcase
    duty_r_d = boundary ? map_r : duty_r_q;
    duty_g_d = boundary ? map_g : duty_g_q;
    duty_b_d = boundary ? map_b : duty_b_q;
  end

  pwm_compare #(.W(W)) u_pwm_r (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt_q),
    .duty (duty_r_q),
    .pin  (RGB_R)
  );

  pwm_compare #(.W(W)) u_pwm_g (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt_q),
    .duty (duty_g_q),
    .pin  (RGB_G)
  );

  pwm_compare #(.W(W)) u_pwm_b (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt_q),
    .duty (duty_b_q),
    .pin  (RGB_B)
  );

  assign segment      = seg_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Self-checking bench for hue_sequencer: HOLD=1 and HOLD=3 instances
// checked every cycle against an arithmetic wheel model.
module tb_hue_sequencer;

  localparam int P    = 8;
  localparam int STEP = 4;
  localparam int MAXD = 8;

  typedef struct {
    bit rst;
    bit en;
    int seg;
    int on_r;
    int on_g;
    int on_b;
  } vec_t;

  logic       clk;
  logic       rst_v [2];
  logic       en_v  [2];
  logic [2:0] pins  [2];
  logic [2:0] seg_o [2];
  logic       ps_o  [2];
  logic       r0, g0, b0, r1, g1, b1;

  int t [2];
  int e [2];
  int hold [2];
  int n_chk;
  int n_fail;

  assign pins[0] = {r0, g0, b0};
  assign pins[1] = {r1, g1, b1};

  hue_sequencer #(
    .PWM_INTERVAL(P), .DUTY_STEP(STEP), .HOLD_PERIODS(1)
  ) dut (
    .clk(clk), .rst_n(rst_v[0]), .en(en_v[0]),
    .RGB_R(r0), .RGB_G(g0), .RGB_B(b0),
    .segment(seg_o[0]), .period_start(ps_o[0])
  );

  hue_sequencer #(
    .PWM_INTERVAL(P), .DUTY_STEP(STEP), .HOLD_PERIODS(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_v[1]), .en(en_v[1]),
    .RGB_R(r1), .RGB_G(g1), .RGB_B(b1),
    .segment(seg_o[1]), .period_start(ps_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // e = enabled boundaries since reset; every hold of them is one ramp step.
  function automatic void ref_duty(input int en_cnt, input int hd,
                                   output int dr, output int dg,
                                   output int db, output int sg);
    int sps;
    int k;
    int r;
    sps = (MAXD + STEP - 1) / STEP;
    k   = (en_cnt / hd) % (6 * sps);
    sg  = k / sps;
    r   = (k % sps) * STEP;
    dr = 0; dg = 0; db = 0;
    case (sg)
      0: begin dr = MAXD;     dg = r;        end
      1: begin dr = MAXD - r; dg = MAXD;     end
      2: begin dg = MAXD;     db = r;        end
      3: begin dg = MAXD - r; db = MAXD;     end
      4: begin dr = r;        db = MAXD;     end
      default: begin dr = MAXD; db = MAXD - r; end
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    logic [2:0] ex [2];
    logic       ens [2];
    logic       rss [2];
    int dr, dg, db, sg, c;
    for (int d = 0; d < 2; d++) begin
      rss[d] = rst_v[d];
      ens[d] = en_v[d];
      ex[d]  = 3'b111;
      if (rss[d]) begin
        ref_duty(e[d], hold[d], dr, dg, db, sg);
        c = t[d] % P;
        ex[d] = {c >= dr, c >= dg, c >= db};
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rss[d]) begin
        if ((t[d] % P) == P - 1 && ens[d]) e[d]++;
        t[d]++;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pins%0d", d), int'(pins[d]), int'(ex[d]));
      if (rss[d]) begin
        ref_duty(e[d], hold[d], dr, dg, db, sg);
        chk($sformatf("seg%0d", d), int'(seg_o[d]), sg);
        chk($sformatf("pstart%0d", d), int'(ps_o[d]), int'((t[d] % P) == 0));
      end else begin
        chk($sformatf("rst_seg%0d", d), int'(seg_o[d]), 0);
        chk($sformatf("rst_ps%0d", d), int'(ps_o[d]), 0);
      end
    end
  endtask

  // Asynchronous reset pulse: outputs must go idle with no clock edge.
  task automatic pulse_reset(input int d);
    rst_v[d] = 1'b0;
    t[d] = 0;
    e[d] = 0;
    #1;
    chk($sformatf("async_pins%0d", d), int'(pins[d]), 7);
    chk($sformatf("async_seg%0d", d), int'(seg_o[d]), 0);
    step();
    rst_v[d] = 1'b1;
  endtask

  vec_t tbl [23];
  int   cr, cg, cb, sg0;

  initial begin
    n_chk = 0;
    n_fail = 0;
    hold[0] = 1;
    hold[1] = 3;
    for (int d = 0; d < 2; d++) begin
      t[d] = 0;
      e[d] = 0;
      rst_v[d] = 1'b1;
      en_v[d] = 1'b1;
    end

    // wheel: periods 0..12
    tbl[0]  = '{0, 1, 0, 8, 0, 0};
    tbl[1]  = '{0, 1, 0, 8, 4, 0};
    tbl[2]  = '{0, 1, 1, 8, 8, 0};
    tbl[3]  = '{0, 1, 1, 4, 8, 0};
    tbl[4]  = '{0, 1, 2, 0, 8, 0};
    tbl[5]  = '{0, 1, 2, 0, 8, 4};
    tbl[6]  = '{0, 1, 3, 0, 8, 8};
    tbl[7]  = '{0, 1, 3, 0, 4, 8};
    tbl[8]  = '{0, 1, 4, 0, 0, 8};
    tbl[9]  = '{0, 1, 4, 4, 0, 8};
    tbl[10] = '{0, 1, 5, 8, 0, 8};
    tbl[11] = '{0, 1, 5, 8, 0, 4};
    tbl[12] = '{0, 1, 0, 8, 0, 0};
    // freeze: en low across periods 3..7
    tbl[13] = '{1, 1, 0, 8, 0, 0};
    tbl[14] = '{0, 1, 0, 8, 4, 0};
    tbl[15] = '{0, 1, 1, 8, 8, 0};
    tbl[16] = '{0, 0, 1, 4, 8, 0};
    tbl[17] = '{0, 0, 1, 4, 8, 0};
    tbl[18] = '{0, 0, 1, 4, 8, 0};
    tbl[19] = '{0, 0, 1, 4, 8, 0};
    tbl[20] = '{0, 0, 1, 4, 8, 0};
    tbl[21] = '{0, 1, 1, 4, 8, 0};
    tbl[22] = '{0, 1, 2, 0, 8, 0};

    #3;
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("init_pins", int'(pins[d]), 7);
      chk("init_seg", int'(seg_o[d]), 0);
      chk("init_ps", int'(ps_o[d]), 0);
    end
    step();
    step();
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].rst) pulse_reset(0);
      en_v[0] = tbl[i].en;
      cr = 0; cg = 0; cb = 0; sg0 = -1;
      for (int k = 0; k < P; k++) begin
        step();
        if (k == 0) sg0 = int'(seg_o[0]);
        cr += int'(!pins[0][2]);
        cg += int'(!pins[0][1]);
        cb += int'(!pins[0][0]);
      end
      chk($sformatf("tbl%0d_seg", i), sg0, tbl[i].seg);
      chk($sformatf("tbl%0d_on_r", i), cr, tbl[i].on_r);
      chk($sformatf("tbl%0d_on_g", i), cg, tbl[i].on_g);
      chk($sformatf("tbl%0d_on_b", i), cb, tbl[i].on_b);
    end

    // period 10 (seg2, r=4): en dropped at cnt 3, raised at cnt 5
    cb = 0;
    for (int k = 0; k < P; k++) begin
      if (k == 3) en_v[0] = 1'b0;
      if (k == 5) en_v[0] = 1'b1;
      step();
      cb += int'(!pins[0][0]);
    end
    chk("mid_en_on_b", cb, 4);
    chk("mid_en_seg", int'(seg_o[0]), 3);

    // HOLD_PERIODS=3: segment advances every 6 periods
    pulse_reset(1);
    en_v[1] = 1'b1;
    for (int i = 1; i <= 96; i++) begin
      step();
      if (i == 47) chk("hold_seg_p5", int'(seg_o[1]), 0);
      if (i == 48) chk("hold_seg_p6", int'(seg_o[1]), 1);
      if (i == 96) chk("hold_seg_p12", int'(seg_o[1]), 2);
    end
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_g_on", int'(pins[1][1]), 0);
    pulse_reset(1);
    step();
    chk("restart_red_on", int'(pins[1][2]), 0);

    for (int i = 0; i < 600; i++) begin
      en_v[0] = 1'($urandom_range(0, 1));
      en_v[1] = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
